// File: rtl/async_pkg.sv
// async_pkg: shared types, frame constants and helpers for the async UART receiver/transmitter
`timescale 1ns/1ps
package async_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  function automatic longint baud_inc(longint clkFrequency, longint baud, longint oversampling, int accWidth);
    return ((baud * oversampling << accWidth) + clkFrequency / 2) / clkFrequency;
  endfunction
  function automatic logic maj3(logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional accumulator producing Baud*Oversampling ticks per second
`timescale 1ns/1ps
module baud_tick_gen
  import async_pkg::*;
#(
  parameter int ClkFrequency = 25000000,
  parameter int Baud = 115200,
  parameter int Oversampling = 16,
  parameter int BaudGeneratorAccWidth = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);
  localparam int W = BaudGeneratorAccWidth;
  localparam longint IncL = baud_inc(ClkFrequency, Baud, Oversampling, W);
  localparam logic [W:0] Inc = IncL[W:0];
  logic [W:0] acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (enable) acc <= {1'b0, acc[W-1:0]} + Inc;
  assign tick = acc[W];
endmodule

// File: rtl/async_receive.sv
// async_receive: 8N1 RS-232 receiver with 3-sample majority voting and a valid/ack holding register
`timescale 1ns/1ps
module async_receive
  import async_pkg::*;
#(
  parameter int ClkFrequency = 25000000,
  parameter int Baud = 115200,
  parameter int Oversampling = 16,
  parameter int BaudGeneratorAccWidth = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_data_valid,
  input  logic       RxD_ack,
  output logic       RxD_frame_err,
  output logic       RxD_overrun,
  output logic       RxD_busy
);
  localparam int SW = $clog2(Oversampling);
  localparam logic [SW-1:0] Mid = SW'(Oversampling / 2);
  localparam logic [SW-1:0] MidLo = Mid - 1'b1;
  localparam logic [SW-1:0] MidHi = Mid + 1'b1;
  localparam logic [SW-1:0] Last = SW'(Oversampling - 1);
  localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);
  if (ClkFrequency < 2 * Baud * Oversampling) begin : g_bad_clk
    $error("ClkFrequency must be at least 2*Baud*Oversampling");
  end
  if (Oversampling < 8 || (Oversampling & (Oversampling - 1)) != 0) begin : g_bad_os
    $error("Oversampling must be a power of 2 and at least 8");
  end
  logic rxMeta, rxS, tick;
  rx_state_t state;
  logic [SW-1:0] scnt;
  logic [2:0] bidx, vote, voteNext;
  logic [DATA_BITS-1:0] shreg;
  logic bitVal, inWindow;
  baud_tick_gen #(
    .ClkFrequency(ClkFrequency),
    .Baud(Baud),
    .Oversampling(Oversampling),
    .BaudGeneratorAccWidth(BaudGeneratorAccWidth)
  ) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .enable(1'b1),
    .tick(tick)
  );
  assign voteNext = {vote[1:0], rxS};
  assign bitVal = maj3(voteNext);
  assign inWindow = scnt == MidLo || scnt == Mid || scnt == MidHi;
  assign RxD_busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta <= 1'b1;
      rxS <= 1'b1;
      state <= IDLE;
      scnt <= '0;
      bidx <= '0;
      vote <= '0;
      shreg <= '0;
      RxD_data <= '0;
      RxD_data_ready <= 1'b0;
      RxD_data_valid <= 1'b0;
      RxD_frame_err <= 1'b0;
      RxD_overrun <= 1'b0;
    end else begin
      rxMeta <= RxD;
      rxS <= rxMeta;
      RxD_data_ready <= 1'b0;
      RxD_frame_err <= 1'b0;
      RxD_data_valid <= RxD_data_valid & ~RxD_ack;
      RxD_overrun <= RxD_overrun & ~RxD_ack;
      if (tick) begin
        if (state != IDLE) scnt <= scnt + 1'b1;
        if (state inside {START, DATA, STOP} && inWindow) vote <= voteNext;
        case (state)
          IDLE: if (!rxS) begin
            state <= START;
            scnt <= SW'(1);
          end
          START: if (scnt == MidHi && bitVal) state <= IDLE;
          else if (scnt == Last) begin
            state <= DATA;
            bidx <= '0;
          end
          DATA: begin
            if (scnt == MidHi) shreg <= {bitVal, shreg[DATA_BITS-1:1]};
            if (scnt == Last) begin
              if (bidx == LastBit) state <= STOP;
              bidx <= bidx + 1'b1;
            end
          end
          STOP: if (scnt == MidHi) begin
            // leave mid-stop so the next start edge can be caught immediately
            if (bitVal) begin
              RxD_data <= shreg;
              RxD_data_ready <= 1'b1;
              RxD_data_valid <= 1'b1;
              RxD_overrun <= (RxD_overrun | RxD_data_valid) & ~RxD_ack;
              state <= IDLE;
            end else begin
              RxD_frame_err <= 1'b1;
              state <= BREAK;
            end
          end
          BREAK: if (rxS) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_async_receive.sv
// tb_async_receive: directed frames against a scoreboard of expected bytes/errors with timing windows
`timescale 1ns/1ps
module tb_async_receive;
  localparam real BitNs = 1.0e9 / 115200.0;
  localparam real TickNs = 40.0 * 65536.0 / 4832.0;
  logic clk = 1'b0, rst_n = 1'b0, RxD = 1'b1, RxD_ack = 1'b0;
  logic [7:0] RxD_data;
  logic RxD_data_ready, RxD_data_valid, RxD_frame_err, RxD_overrun, RxD_busy;
  typedef struct {logic err; logic [7:0] b; realtime lo; realtime hi;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [7:0] mData = '0;
  logic mValid = 1'b0, mOv = 1'b0;
  always #20 clk = ~clk;
  async_receive dut (
    .clk(clk),
    .rst_n(rst_n),
    .RxD(RxD),
    .RxD_data(RxD_data),
    .RxD_data_ready(RxD_data_ready),
    .RxD_data_valid(RxD_data_valid),
    .RxD_ack(RxD_ack),
    .RxD_frame_err(RxD_frame_err),
    .RxD_overrun(RxD_overrun),
    .RxD_busy(RxD_busy)
  );
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $realtime);
    end
  endtask
  // model: a good frame delivers its byte at 153 ticks (+/-1 tick, +sync) after its start edge
  initial begin
    exp_t e;
    logic got;
    forever begin
      @(posedge clk);
      #1;
      got = 1'b0;
      if (!rst_n) begin
        mData = '0;
        mValid = 1'b0;
        mOv = 1'b0;
        q.delete();
        check("reset_outputs", {RxD_data, RxD_data_ready, RxD_data_valid, RxD_frame_err, RxD_overrun, RxD_busy}, 0);
      end else begin
        if (RxD_data_ready || RxD_frame_err) begin
          if (q.size() == 0) begin
            check("spurious_ready", RxD_data_ready, 0);
            check("spurious_frame_err", RxD_frame_err, 0);
          end else begin
            e = q.pop_front();
            check("event_kind", {RxD_data_ready, RxD_frame_err}, {!e.err, e.err});
            check("event_time", $realtime >= e.lo && $realtime <= e.hi, 1);
            if (!e.err) begin
              check("rx_byte", RxD_data, e.b);
              check("busy_mid_stop", RxD_busy, 0);
              mOv = !RxD_ack && (mOv || mValid);
              mValid = 1'b1;
              mData = e.b;
              got = 1'b1;
            end else check("busy_break", RxD_busy, 1);
          end
        end
        if (!got && RxD_ack) begin
          mValid = 1'b0;
          mOv = 1'b0;
        end
        check("data_hold", RxD_data, mData);
        check("valid", RxD_data_valid, mValid);
        check("overrun", RxD_overrun, mOv);
      end
    end
  end
  task automatic sendFrame(logic [7:0] b, real bitNs, logic stopBit, int glitchBit, logic expectIt);
    realtime t0;
    t0 = $realtime;
    RxD = 1'b0;
    if (expectIt) q.push_back('{!stopBit, b, t0 + 153.0 * TickNs - 80.0, t0 + 154.0 * TickNs + 240.0});
    #(bitNs);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      if (i == glitchBit) begin
        #(bitNs / 2.0 - 150.0);
        RxD = ~b[i];
        #300;
        RxD = b[i];
        #(bitNs / 2.0 - 150.0);
      end else #(bitNs);
    end
    RxD = stopBit;
    #(bitNs);
    RxD = 1'b1;
  endtask
  task automatic waitEvents();
    int n = 0;
    while (q.size() != 0 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    check("event_arrived", q.size(), 0);
    q.delete();
    repeat (5) @(posedge clk);
    #2;
  endtask
  task automatic ack();
    @(negedge clk);
    RxD_ack = 1'b1;
    @(negedge clk);
    RxD_ack = 1'b0;
    @(posedge clk);
    #2;
  endtask
  initial begin
    #3500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    check("reset_data", RxD_data, 8'h00);
    check("reset_busy", RxD_busy, 0);
    rst_n = 1'b1;
    #(3.0 * BitNs);
    sendFrame(8'hA5, BitNs, 1'b1, -1, 1'b1);
    waitEvents();
    check("t1_data", RxD_data, 8'hA5);
    check("t1_valid", RxD_data_valid, 1);
    ack();
    check("t1_ack_valid", RxD_data_valid, 0);
    #(2.0 * BitNs);
    sendFrame(8'h3C, BitNs, 1'b1, -1, 1'b1);
    sendFrame(8'hC3, BitNs, 1'b1, -1, 1'b1);
    waitEvents();
    check("t2_data", RxD_data, 8'hC3);
    check("t2_overrun", RxD_overrun, 1);
    ack();
    check("t2_ack_valid", RxD_data_valid, 0);
    check("t2_ack_overrun", RxD_overrun, 0);
    #(2.0 * BitNs);
    RxD = 1'b0;
    #(4.0 * TickNs);
    RxD = 1'b1;
    #(3.0 * BitNs);
    check("t3_glitch_busy", RxD_busy, 0);
    check("t3_glitch_data", RxD_data, 8'hC3);
    sendFrame(8'h55, BitNs, 1'b1, -1, 1'b1);
    waitEvents();
    check("t3_data", RxD_data, 8'h55);
    #(2.0 * BitNs);
    sendFrame(8'h0F, BitNs, 1'b0, -1, 1'b1);
    #(2.0 * BitNs);
    waitEvents();
    check("t4_err_data", RxD_data, 8'h55);
    check("t4_err_valid", RxD_data_valid, 1);
    check("t4_err_busy", RxD_busy, 0);
    ack();
    sendFrame(8'hF0, BitNs, 1'b1, -1, 1'b1);
    waitEvents();
    check("t4_data", RxD_data, 8'hF0);
    ack();
    #(2.0 * BitNs);
    sendFrame(8'h81, BitNs / 1.03, 1'b1, -1, 1'b1);
    waitEvents();
    check("t5_fast", RxD_data, 8'h81);
    ack();
    #(2.0 * BitNs);
    sendFrame(8'h81, BitNs / 0.97, 1'b1, -1, 1'b1);
    waitEvents();
    check("t5_slow", RxD_data, 8'h81);
    ack();
    #(2.0 * BitNs);
    sendFrame(8'h81, BitNs, 1'b1, 3, 1'b1);
    waitEvents();
    check("t5_glitch", RxD_data, 8'h81);
    check("t5_valid", RxD_data_valid, 1);
    #(2.0 * BitNs);
    fork
      sendFrame(8'hFF, BitNs, 1'b1, -1, 1'b0);
      begin
        #(5.5 * BitNs);
        rst_n = 1'b0;
        #100;
        check("t6_rst_data", RxD_data, 8'h00);
        check("t6_rst_valid", RxD_data_valid, 0);
        check("t6_rst_busy", RxD_busy, 0);
        rst_n = 1'b1;
      end
    join
    #(2.0 * BitNs);
    check("t6_idle_after", RxD_busy, 0);
    sendFrame(8'h12, BitNs, 1'b1, -1, 1'b1);
    waitEvents();
    check("t6_data", RxD_data, 8'h12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/async_receive.md
Name: async_receive

Overview:
RS-232 receive counterpart of the existing UART transmitter. It converts the asynchronous RxD line into 8-bit bytes, using the 8N1 frame format with LSB first. Bits are recovered by oversampling each bit period and taking a 3-sample majority vote. Received bytes go to the host logic through a valid/ack holding register, with framing-error and overrun flags.

Parameters:
ClkFrequency, 25000000, clk frequency in Hz.
Baud, 115200, line bit rate.
Oversampling, 16, sample ticks per bit; must be a power of 2 and at least 8.
BaudGeneratorAccWidth, 16, width of the fractional tick accumulator.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
RxD  in  1  serial input; asynchronous to clk; idle high.
RxD_data  out  8  last good received byte; held until the next good byte.
RxD_data_ready  out  1  one-cycle pulse when RxD_data is updated.
RxD_data_valid  out  1  high from the data_ready cycle until RxD_ack.
RxD_ack  in  1  host consumed RxD_data; clears RxD_data_valid.
RxD_frame_err  out  1  one-cycle pulse on a bad stop bit.
RxD_overrun  out  1  sticky; set when a good byte arrives while valid=1; cleared by RxD_ack.
RxD_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. All outputs 0. RxD_data=8'h00. Synchronizer flops preset to 1. Accumulator cleared. Reset asserted mid-frame abandons the frame and produces no flag pulses.
- Synchronizer: 2-flop chain on RxD, giving rx_s. All decisions use rx_s.
- Tick generator: free-running accumulator of BaudGeneratorAccWidth+1 bits.
  - Increment = round(Baud*Oversampling*2^BaudGeneratorAccWidth/ClkFrequency), computed at elaboration in 64-bit integer math; default 4832.
  - tick = accumulator MSB; the MSB is dropped on each add.
  - Elaboration error if ClkFrequency < 2*Baud*Oversampling.
- Counters: sample counter scnt (log2 Oversampling bits) and bit index bidx (3 bits). Both advance only on tick.
- Voting: mid = Oversampling/2. On ticks with scnt = mid-1, mid and mid+1, rx_s is shifted into a 3-bit vote register. The bit value is the majority of the 3, taken at scnt = mid+1.
- IDLE: on a tick with rx_s=0, go to START with scnt=1.
- START: at scnt = mid+1, if vote=1 it is a false start: return to IDLE, no flags. Otherwise continue until scnt wraps to 0, then go to DATA with bidx=0.
- DATA: at each vote point, shift the voted bit in LSB-first (shift right, new bit into [7]). On scnt wrap: if bidx=7 go to STOP, else bidx+1.
- STOP, decided at the vote point:
  - vote=1: RxD_data <= shift register; RxD_data_ready=1 for exactly 1 cycle; RxD_data_valid=1. If RxD_data_valid was already 1 and RxD_ack is not high that cycle, set RxD_overrun. State goes to IDLE immediately (mid-stop), allowing resync on the next start edge.
  - vote=0: RxD_frame_err pulses 1 cycle; RxD_data, RxD_data_valid and RxD_data_ready are unchanged; go to BREAK.
- BREAK: wait for a tick with rx_s=1, then go to IDLE. A continuous low line yields exactly one frame_err.
- Handshake: RxD_ack clears valid and overrun in the next cycle. If ack and a new byte delivery coincide, the delivery wins: valid stays 1 and overrun is not set. ack while valid=0 has no effect.
- Latency: RxD_data_ready rises 2 clk + (9*Oversampling + mid + 1) ticks after the RxD falling edge. The 2 clk come from the synchronizer; tick-phase jitter is at most 1 tick.
- Tolerance: frames within ±3% baud mismatch must decode correctly.

Decomposition:
- Package async_pkg:
  - rx_state_t enum: IDLE, START, DATA, STOP, BREAK.
  - function baud_inc(ClkFrequency, Baud, Oversampling, AccWidth).
  - frame constants: DATA_BITS=8, STOP_BITS=1.
- Sub-module baud_tick_gen(clk, rst_n, enable, tick): the accumulator; enable is tied to 1 here. It is reusable by the transmitter.

Test Plan:
1. Send 8'hA5 at exactly 115200 baud, then stop bit 1. Expect: one data_ready pulse, RxD_data=8'hA5, valid=1, frame_err never pulses, busy falls at mid-stop.
2. Send 8'h3C, then 8'hC3 back-to-back with no ack. Expect: second delivery gives RxD_data=8'hC3 and overrun=1. Then pulse ack: valid=0 and overrun=0 on the next cycle.
3. RxD low glitch of 4 ticks (< mid) while idle. Expect: return to IDLE, no data_ready, no frame_err. Then send 8'h55: expect RxD_data=8'h55.
4. Send 8'h0F with stop bit 0, line then high. Expect: one frame_err pulse, RxD_data keeps its previous value, valid unchanged. Then send 8'hF0: expect it received correctly.
5. Send 8'h81 at Baud*1.03, then at Baud*0.97. Expect RxD_data=8'h81 both times. Also inject a single 1-tick inverted glitch mid-bit: the majority vote must still give 8'h81.
6. Assert rst_n=0 during bit 4 of 8'hFF, then release. Expect: all outputs 0, no pulses. Then send 8'h12: expect RxD_data=8'h12.
